rv_boot_rom_wb: RTL
===================

RV_BOOT_ROM_WB -- requirements
Module: rv_boot_rom_wb

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words; power of two, 4..4096.
REQ-002 SHALL have parameter LATENCY, default 1, cycles from accepted request to ack/err; legal range 1..4.
REQ-003 SHALL have parameter DEFAULT_INSN, default 32'h0FC0006F, word returned for unwritten or out-of-range reads (JAL x0, +0xFC).
REQ-004 SHALL have parameter CTRL_ADDR, default 32'hFFFF_FFFC, byte address of the lock register.
REQ-005 SHALL have parameter LOCK_AT_RESET, default 0, lock state after reset.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 i_wb_cyc  input  1  bus cycle valid.
REQ-009 i_wb_stb  input  1  request strobe.
REQ-010 i_wb_we  input  1  1 = write, 0 = read.
REQ-011 i_wb_addr  input  32  byte address; word index = addr[log2(DEPTH)+1:2].
REQ-012 i_wb_sel  input  4  byte enables for writes.
REQ-013 i_wb_data  input  32  write data.
REQ-014 o_wb_ack  output  1  one-cycle success response.
REQ-015 o_wb_err  output  1  one-cycle error response.
REQ-016 o_wb_stall  output  1  always 0.
REQ-017 o_wb_data  output  32  read data, valid only with o_wb_ack.
REQ-018 o_locked  output  1  current lock state.

Function
REQ-019 Request accepted in a cycle SHALL be i_wb_cyc & i_wb_stb (stall constant 0); one request per cycle, fully pipelined.
REQ-020 Each accepted request SHALL produce exactly one of o_wb_ack/o_wb_err exactly LATENCY cycles later, in request order.
REQ-021 In range: addr[31:log2(DEPTH)+2]==0 and addr[1:0] ignored; all other addresses except CTRL_ADDR out of range.
REQ-022 Per-word valid bitmap (DEPTH bits) SHALL track written words; cleared by reset; memory array itself not reset.
REQ-023 In-range read SHALL return stored word if valid bit set, else DEFAULT_INSN; ack.
REQ-024 Out-of-range read SHALL return DEFAULT_INSN with ack.
REQ-025 Read of CTRL_ADDR SHALL return {31'b0, locked} with ack.
REQ-026 In-range write while unlocked SHALL update bytes selected by i_wb_sel, set valid bit, ack; unselected bytes of a previously-invalid word read as corresponding DEFAULT_INSN bytes.
REQ-027 Write while locked, or out-of-range write, SHALL not modify state and SHALL respond err.
REQ-028 Write to CTRL_ADDR with i_wb_sel[0] & data[0]=1 SHALL set locked (ack); lock is sticky, cleared only by reset; writing 0 SHALL ack and leave state unchanged.
REQ-029 Write takes effect at end of accept cycle; read accepted the next cycle SHALL return new data; lock likewise applies to requests accepted the next cycle onward.
REQ-030 If i_wb_cyc is low in any cycle, all in-flight responses SHALL be discarded (no ack/err issued); writes already accepted remain committed.
REQ-031 o_wb_data SHALL be 0 in cycles without ack.
REQ-032 Simultaneous ack and err SHALL never occur.

Reset
REQ-033 While resetn low: o_wb_ack=0, o_wb_err=0, o_wb_data=0, pipeline emptied, valid bitmap=0, locked=LOCK_AT_RESET, o_locked follows.
REQ-034 Reset asserted mid-transaction SHALL drop all pending responses; first request accepted after deassertion behaves as after power-up.

Verification
REQ-035 Power-up, LATENCY=1: read addr 0x0 -> ack next cycle, data 0x0FC0006F; read 0x400 (DEPTH=256) -> ack, 0x0FC0006F.
REQ-036 Write 0x00600313 to addr 0x8 sel=4'hF, then back-to-back read 0x8 -> ack, data 0x00600313; sel=4'h1 write of 0xAA to fresh addr 0xC -> read 0x0FC000AA.
REQ-037 Write 1 to CTRL_ADDR -> ack, o_locked=1; write 0x8 -> err, read 0x8 still 0x00600313; read CTRL_ADDR -> 0x1.
REQ-038 LATENCY=3: 4 back-to-back reads -> 4 acks on cycles 3..6 after first accept, in order; drop cyc after second accept -> no acks for any of them.
REQ-039 Assert resetn low while two requests in flight -> no responses, o_locked=LOCK_AT_RESET, previously written addr 0x8 reads 0x0FC0006F.
REQ-040 Out-of-range write 0x1000 unlocked -> err only, no ack, no state change.

Source files
------------

// File: rtl/rv_boot_rom_wb_if.sv
// Wishbone pipelined bus bundle for the boot ROM.
// Signal names keep the i_/o_ prefixes seen from the ROM side.
interface rv_boot_rom_wb_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [31:0] i_wb_addr;
  logic [3:0]  i_wb_sel;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic        o_wb_err;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_sel, i_wb_data,
    output o_wb_ack, o_wb_err, o_wb_stall, o_wb_data
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_sel, i_wb_data,
    input  o_wb_ack, o_wb_err, o_wb_stall, o_wb_data
  );
endinterface

// File: rtl/rv_boot_rom_wb.sv
// Writable-until-locked boot ROM on a pipelined Wishbone slave port.
// Responses are computed at accept time and delayed LATENCY cycles.
module rv_boot_rom_wb #(
  parameter int          DEPTH         = 256,
  parameter int          LATENCY       = 1,
  parameter logic [31:0] DEFAULT_INSN  = 32'h0FC0006F,
  parameter logic [31:0] CTRL_ADDR     = 32'hFFFF_FFFC,
  parameter bit          LOCK_AT_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  rv_boot_rom_wb_if.slave  wb,
  output logic             o_locked
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic              accept;
  logic              is_ctrl;
  logic              in_range;
  logic [AW-1:0]     idx;
  logic [31:0]       mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic              locked;
  logic [31:0]       cur_word;
  logic [31:0]       wr_word;
  logic              wr_mem;
  logic              set_lock;
  rsp_t              rsp_now;
  logic [LATENCY:1]  vld_pipe;
  rsp_t              rsp_pipe [1:LATENCY];

  assign accept   = wb.i_wb_cyc & wb.i_wb_stb;
  assign is_ctrl  = (wb.i_wb_addr & ~32'h3) == (CTRL_ADDR & ~32'h3);
  assign in_range = (wb.i_wb_addr[31:AW+2] == '0);
  assign idx      = wb.i_wb_addr[AW+1:2];

  // Never-written words read back as the default jump, including for merges.
  assign cur_word = valid[idx] ? mem[idx] : DEFAULT_INSN;

  always_comb begin
    wr_word = cur_word;
    for (int b = 0; b < 4; b++)
      if (wb.i_wb_sel[b]) wr_word[8*b +: 8] = wb.i_wb_data[8*b +: 8];
  end

  assign wr_mem   = accept & wb.i_wb_we & in_range & ~is_ctrl & ~locked;
  assign set_lock = accept & wb.i_wb_we & is_ctrl & wb.i_wb_sel[0] & wb.i_wb_data[0];

  always_comb begin
    rsp_now = '0;
    if (wb.i_wb_we)
      rsp_now.err = ~is_ctrl & (~in_range | locked);
    else if (is_ctrl)
      rsp_now.data = {31'b0, locked};
    else if (in_range)
      rsp_now.data = cur_word;
    else
      rsp_now.data = DEFAULT_INSN;
  end

  always_ff @(posedge clk)
    if (wr_mem) mem[idx] <= wr_word;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid  <= '0;
      locked <= LOCK_AT_RESET;
    end else begin
      if (wr_mem)   valid[idx] <= 1'b1;
      if (set_lock) locked     <= 1'b1;
    end
  end

  // Dropping cyc abandons everything in flight; committed writes stay.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      for (int i = 1; i <= LATENCY; i++) rsp_pipe[i] <= '0;
    end else begin
      if (!wb.i_wb_cyc) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[1] <= accept;
        for (int i = 2; i <= LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
      rsp_pipe[1] <= rsp_now;
      for (int i = 2; i <= LATENCY; i++) rsp_pipe[i] <= rsp_pipe[i-1];
    end
  end

  assign wb.o_wb_ack   = wb.i_wb_cyc & vld_pipe[LATENCY] & ~rsp_pipe[LATENCY].err;
  assign wb.o_wb_err   = wb.i_wb_cyc & vld_pipe[LATENCY] &  rsp_pipe[LATENCY].err;
  assign wb.o_wb_data  = wb.o_wb_ack ? rsp_pipe[LATENCY].data : 32'h0;
  assign wb.o_wb_stall = 1'b0;
  assign o_locked      = locked;
endmodule
